match_controller: RTL and testbench
===================================

// Module: match_controller
// PURPOSE
//  Match/round sequencer for the fighting game: IDLE -> COUNTDOWN -> FIGHT -> ROUND_END -> MATCH_END.
//  Drives health_manager through game_active and a one-cycle round_reset pulse, which the top level ORs
//  into health_manager's active-high reset. Consumes its health and game-over outputs, runs the round
//  clock, and counts round wins until one player has ROUNDS_TO_WIN wins or MAX_ROUNDS rounds are played.
// PARAMETERS
//  FPS              60   clk_game ticks per displayed second
//  COUNTDOWN_FRAMES 180  pre-round freeze length, in frames
//  ROUND_END_FRAMES 120  post-round freeze length, in frames
//  ROUND_TIME_SEC   60   round time limit, in seconds (max 99)
//  ROUNDS_TO_WIN    2    round wins needed to take the match
//  MAX_ROUNDS       5    hard cap on rounds per match
// PORTS
//  clk_game      in   1  game frame clock; single clock domain
//  reset_n       in   1  asynchronous, active-low reset
//  start_btn     in   1  synchronised level; rising edge detected internally
//  pause_btn     in   1  synchronised level; rising edge toggles pause during FIGHT
//  p1_health     in   3  from health_manager
//  p2_health     in   3  from health_manager
//  game_over     in   1  from health_manager
//  p1_wins       in   1  from health_manager
//  p2_wins       in   1  from health_manager
//  draw_game     in   1  from health_manager
//  game_active   out  1  registered; 1 only in FIGHT and not paused
//  round_reset   out  1  one-cycle pulse; restores health and block counts to 3
//  state         out  3  0=IDLE 1=COUNTDOWN 2=FIGHT 3=ROUND_END 4=MATCH_END
//  paused        out  1  pause flag
//  round_num     out  3  current round, 1-based; 0 in IDLE
//  round_seconds out  7  seconds remaining in the round
//  p1_rounds     out  3  round wins for P1
//  p2_rounds     out  3  round wins for P2
//  match_over    out  1  high in MATCH_END
//  match_winner  out  2  00=none/draw 01=P1 10=P2; valid while match_over=1
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE, and all internal counters and edge registers are 0.
//  All outputs are registered. Start and pause edges are computed against the previous-cycle level.
//  IDLE: on a start edge, pulse round_reset and, in the same cycle, clear both round counts,
//   set round_num=1, load the frame counter with COUNTDOWN_FRAMES-1, and go to COUNTDOWN.
//  COUNTDOWN: the frame counter decrements each cycle. In the cycle after it reads 0, enter FIGHT with
//   round_seconds=ROUND_TIME_SEC and the sub-second divider at 0. game_active=1 from that first FIGHT cycle.
//  FIGHT (not paused): the divider counts 0..FPS-1. On wrap, round_seconds decrements, saturating at 0.
//   - Exit on game_over: if p1_wins, p1_rounds+1; if p2_wins, p2_rounds+1; if draw_game, no award.
//   - Exit on timeout (round_seconds==0 and game_over=0): the higher health wins the round;
//     equal health is a draw with no award.
//   - game_over takes priority over timeout in the same cycle.
//   - On exit, game_active=0 in the next cycle. Load ROUND_END_FRAMES-1, clear paused, go to ROUND_END.
//  Pause: a pause edge in FIGHT toggles paused. While paused, game_active=0 and both the divider and
//   round_seconds freeze. Pause edges in other states are ignored. A pause edge in the same cycle as
//   a FIGHT exit is ignored.
//  ROUND_END: the frame counter decrements. When it reads 0:
//   - If p1_rounds or p2_rounds == ROUNDS_TO_WIN, or round_num == MAX_ROUNDS: go to MATCH_END.
//     match_winner is the side with more rounds; equal counts give 00.
//   - Otherwise: pulse round_reset, increment round_num, load COUNTDOWN_FRAMES-1, go to COUNTDOWN.
//  MATCH_END: match_over=1, and all counts and match_winner hold. A start edge goes to IDLE, clears
//   match_over, round_num and match_winner, and keeps p1_rounds/p2_rounds for display. Leaving IDLE
//   requires a further start edge.
//  The start edge is ignored outside IDLE and MATCH_END.
//  round_reset is never asserted in FIGHT, so stale game_over is never sampled across rounds.
//  Round counters saturate at 7. Asynchronous reset mid-match returns immediately to IDLE with all outputs 0.
// TESTING
//  1. Start edge in IDLE -> one-cycle round_reset, state=1, round_num=1. After 180 cycles, state=2 and
//     game_active=1 the same cycle.
//  2. FIGHT, pulse p1_wins+game_over -> p1_rounds=1, game_active=0 next cycle. After 120 frames:
//     round_reset pulse, round_num=2. Repeat -> MATCH_END, match_winner=01.
//  3. FIGHT with no hits (FPS=4, ROUND_TIME_SEC=3) -> timeout after 12 cycles. p1_health=3, p2_health=2
//     -> p1_rounds+1. Equal health -> no award.
//  4. Pause edge at round_seconds=40 -> game_active=0 and the timer is frozen 100 cycles.
//     Second edge -> resumes at 40.
//  5. Five draws (draw_game+game_over) -> MATCH_END after round 5, match_winner=00.
//  6. game_over and timeout in the same cycle -> game_over path used. reset_n low mid-FIGHT
//     -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/match_controller.sv
// Round/match sequencer: countdown, fight clock with pause, round-end freeze and win tally.
// Drives health_manager via game_active and a one-cycle round_reset pulse.
module match_controller #(
    parameter int unsigned FPS              = 60,
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned ROUND_END_FRAMES = 120,
    parameter int unsigned ROUND_TIME_SEC   = 60,
    parameter int unsigned ROUNDS_TO_WIN    = 2,
    parameter int unsigned MAX_ROUNDS       = 5
) (
    input  logic       clk_game,
    input  logic       reset_n,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [2:0] p1_health,
    input  logic [2:0] p2_health,
    input  logic       game_over,
    input  logic       p1_wins,
    input  logic       p2_wins,
    input  logic       draw_game,
    output logic       game_active,
    output logic       round_reset,
    output logic [2:0] state,
    output logic       paused,
    output logic [2:0] round_num,
    output logic [6:0] round_seconds,
    output logic [2:0] p1_rounds,
    output logic [2:0] p2_rounds,
    output logic       match_over,
    output logic [1:0] match_winner
);

    localparam int unsigned FRAMES_MAX = (COUNTDOWN_FRAMES > ROUND_END_FRAMES) ?
                                         COUNTDOWN_FRAMES : ROUND_END_FRAMES;
    localparam int unsigned FW = $clog2(FRAMES_MAX + 1);
    localparam int unsigned DW = (FPS > 1) ? $clog2(FPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [FW-1:0] frame_cnt, frame_cnt_nxt;
    logic [DW-1:0] div_cnt, div_cnt_nxt;
    logic          start_q, pause_q;

    logic       game_active_nxt, round_reset_nxt, paused_nxt, match_over_nxt;
    logic [2:0] round_num_nxt, p1_rounds_nxt, p2_rounds_nxt;
    logic [6:0] round_seconds_nxt;
    logic [1:0] match_winner_nxt;

    logic start_edge, pause_edge, frame_zero, fight_exit, match_done;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    assign start_edge = start_btn & ~start_q;
    assign pause_edge = pause_btn & ~pause_q;
    assign frame_zero = (frame_cnt == '0);
    // Exits are only taken while running; a pause edge in an exit cycle is thereby dropped.
    assign fight_exit = (state_q == S_FIGHT) && !paused && (game_over || round_seconds == '0);
    assign match_done = (p1_rounds == 3'(ROUNDS_TO_WIN)) || (p2_rounds == 3'(ROUNDS_TO_WIN)) ||
                        (round_num == 3'(MAX_ROUNDS));

    assign state = state_q;

    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_edge) state_d = S_COUNTDOWN;
            S_COUNTDOWN: if (frame_zero) state_d = S_FIGHT;
            S_FIGHT:     if (fight_exit) state_d = S_ROUND_END;
            S_ROUND_END: if (frame_zero) state_d = match_done ? S_MATCH_END : S_COUNTDOWN;
            S_MATCH_END: if (start_edge) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_nxt     = frame_cnt;
        div_cnt_nxt       = div_cnt;
        game_active_nxt   = 1'b0;
        round_reset_nxt   = 1'b0;
        paused_nxt        = paused;
        match_over_nxt    = match_over;
        round_num_nxt     = round_num;
        round_seconds_nxt = round_seconds;
        p1_rounds_nxt     = p1_rounds;
        p2_rounds_nxt     = p2_rounds;
        match_winner_nxt  = match_winner;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    round_reset_nxt = 1'b1;
                    p1_rounds_nxt   = '0;
                    p2_rounds_nxt   = '0;
                    round_num_nxt   = 3'd1;
                    frame_cnt_nxt   = FW'(COUNTDOWN_FRAMES - 1);
                end
            end
            S_COUNTDOWN: begin
                if (frame_zero) begin
                    round_seconds_nxt = 7'(ROUND_TIME_SEC);
                    div_cnt_nxt       = '0;
                    game_active_nxt   = 1'b1;
                end else begin
                    frame_cnt_nxt = frame_cnt - FW'(1);
                end
            end
            S_FIGHT: begin
                if (fight_exit) begin
                    frame_cnt_nxt = FW'(ROUND_END_FRAMES - 1);
                    paused_nxt    = 1'b0;
                    if (game_over) begin
                        if (p1_wins)      p1_rounds_nxt = sat_inc(p1_rounds);
                        else if (p2_wins) p2_rounds_nxt = sat_inc(p2_rounds);
                    end else if (p1_health > p2_health) begin
                        p1_rounds_nxt = sat_inc(p1_rounds);
                    end else if (p2_health > p1_health) begin
                        p2_rounds_nxt = sat_inc(p2_rounds);
                    end
                end else begin
                    paused_nxt      = paused ^ pause_edge;
                    game_active_nxt = ~(paused ^ pause_edge);
                    if (!paused) begin
                        if (div_cnt == DW'(FPS - 1)) begin
                            div_cnt_nxt = '0;
                            if (round_seconds != '0) round_seconds_nxt = round_seconds - 7'd1;
                        end else begin
                            div_cnt_nxt = div_cnt + DW'(1);
                        end
                    end
                end
            end
            S_ROUND_END: begin
                if (frame_zero) begin
                    if (match_done) begin
                        match_over_nxt = 1'b1;
                        if (p1_rounds > p2_rounds)      match_winner_nxt = 2'b01;
                        else if (p2_rounds > p1_rounds) match_winner_nxt = 2'b10;
                        else                            match_winner_nxt = 2'b00;
                    end else begin
                        round_reset_nxt = 1'b1;
                        round_num_nxt   = round_num + 3'd1;
                        frame_cnt_nxt   = FW'(COUNTDOWN_FRAMES - 1);
                    end
                end else begin
                    frame_cnt_nxt = frame_cnt - FW'(1);
                end
            end
            S_MATCH_END: begin
                if (start_edge) begin
                    match_over_nxt   = 1'b0;
                    round_num_nxt    = '0;
                    match_winner_nxt = 2'b00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt     <= '0;
            div_cnt       <= '0;
            start_q       <= 1'b0;
            pause_q       <= 1'b0;
            game_active   <= 1'b0;
            round_reset   <= 1'b0;
            paused        <= 1'b0;
            match_over    <= 1'b0;
            round_num     <= '0;
            round_seconds <= '0;
            p1_rounds     <= '0;
            p2_rounds     <= '0;
            match_winner  <= '0;
        end else begin
            frame_cnt     <= frame_cnt_nxt;
            div_cnt       <= div_cnt_nxt;
            start_q       <= start_btn;
            pause_q       <= pause_btn;
            game_active   <= game_active_nxt;
            round_reset   <= round_reset_nxt;
            paused        <= paused_nxt;
            match_over    <= match_over_nxt;
            round_num     <= round_num_nxt;
            round_seconds <= round_seconds_nxt;
            p1_rounds     <= p1_rounds_nxt;
            p2_rounds     <= p2_rounds_nxt;
            match_winner  <= match_winner_nxt;
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with FPS=4, 45 s rounds, 180/120-frame freezes.
module tb_match_controller;

    logic       clk_game = 1'b0;
    logic       reset_n;
    logic       start_btn, pause_btn;
    logic [2:0] p1_health, p2_health;
    logic       game_over, p1_wins, p2_wins, draw_game;
    logic       game_active, round_reset, paused, match_over;
    logic [2:0] state, round_num, p1_rounds, p2_rounds;
    logic [6:0] round_seconds;
    logic [1:0] match_winner;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_game = ~clk_game;

    match_controller #(
        .FPS(4), .COUNTDOWN_FRAMES(180), .ROUND_END_FRAMES(120),
        .ROUND_TIME_SEC(45), .ROUNDS_TO_WIN(2), .MAX_ROUNDS(5)
    ) dut (
        .clk_game(clk_game), .reset_n(reset_n), .start_btn(start_btn), .pause_btn(pause_btn),
        .p1_health(p1_health), .p2_health(p2_health), .game_over(game_over),
        .p1_wins(p1_wins), .p2_wins(p2_wins), .draw_game(draw_game),
        .game_active(game_active), .round_reset(round_reset), .state(state), .paused(paused),
        .round_num(round_num), .round_seconds(round_seconds), .p1_rounds(p1_rounds),
        .p2_rounds(p2_rounds), .match_over(match_over), .match_winner(match_winner)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_game);
            #1;
        end
    endtask

    // From the cycle COUNTDOWN was entered, runs to the first FIGHT cycle.
    task automatic run_countdown;
        tick(179);
        n_cmp++; if (state !== 3'd1 || game_active !== 1'b0) begin n_bad++;
            $display("FAIL countdown_last: state=%0d ga=%0b want 1/0", state, game_active); end
        tick(1);
        n_cmp++; if (state !== 3'd2 || game_active !== 1'b1 || round_seconds !== 7'd45) begin n_bad++;
            $display("FAIL fight_entry: state=%0d ga=%0b sec=%0d want 2/1/45", state, game_active, round_seconds); end
    endtask

    // From the cycle ROUND_END was entered, runs to the following state.
    task automatic run_round_end(input logic [2:0] exp_state);
        tick(119);
        n_cmp++; if (state !== 3'd3 || round_reset !== 1'b0 || game_active !== 1'b0) begin n_bad++;
            $display("FAIL round_end_last: state=%0d rr=%0b ga=%0b want 3/0/0", state, round_reset, game_active); end
        tick(1);
        n_cmp++; if (state !== exp_state) begin n_bad++;
            $display("FAIL round_end_exit: state=%0d want %0d", state, exp_state); end
        if (exp_state == 3'd1) begin
            n_cmp++; if (round_reset !== 1'b1) begin n_bad++;
                $display("FAIL round_reset_pulse: got %0b want 1", round_reset); end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start_btn = 0; pause_btn = 0; p1_health = 3'd3; p2_health = 3'd3;
        game_over = 0; p1_wins = 0; p2_wins = 0; draw_game = 0;
        tick(3);
        n_cmp++; if ({game_active, round_reset, state, paused, round_num, round_seconds,
                      p1_rounds, p2_rounds, match_over, match_winner} !== '0) begin n_bad++;
            $display("FAIL reset_outputs: state=%0d ga=%0b rn=%0d sec=%0d want all 0",
                     state, game_active, round_num, round_seconds); end
        reset_n = 1'b1;
        tick(2);
        pause_btn = 1'b1;
        tick(1);
        n_cmp++; if (paused !== 1'b0 || state !== 3'd0) begin n_bad++;
            $display("FAIL pause_in_idle: paused=%0b state=%0d want 0/0", paused, state); end
        pause_btn = 1'b0;
        tick(1);
    endtask

    task automatic test_start;
        start_btn = 1'b1;
        tick(1);
        n_cmp++; if (round_reset !== 1'b1 || state !== 3'd1 || round_num !== 3'd1) begin n_bad++;
            $display("FAIL start_edge: rr=%0b state=%0d rn=%0d want 1/1/1", round_reset, state, round_num); end
        start_btn = 1'b0;
        tick(1);
        n_cmp++; if (round_reset !== 1'b0 || state !== 3'd1) begin n_bad++;
            $display("FAIL rr_one_cycle: rr=%0b state=%0d want 0/1", round_reset, state); end
        tick(178);
        n_cmp++; if (state !== 3'd1 || game_active !== 1'b0) begin n_bad++;
            $display("FAIL countdown_179: state=%0d ga=%0b want 1/0", state, game_active); end
        tick(1);
        n_cmp++; if (state !== 3'd2 || game_active !== 1'b1 || round_seconds !== 7'd45) begin n_bad++;
            $display("FAIL countdown_180: state=%0d ga=%0b sec=%0d want 2/1/45", state, game_active, round_seconds); end
    endtask

    task automatic test_ko_match;
        game_over = 1'b1; p1_wins = 1'b1;
        tick(1);
        n_cmp++; if (state !== 3'd3 || game_active !== 1'b0 || p1_rounds !== 3'd1) begin n_bad++;
            $display("FAIL ko1: state=%0d ga=%0b p1r=%0d want 3/0/1", state, game_active, p1_rounds); end
        game_over = 1'b0; p1_wins = 1'b0;
        run_round_end(3'd1);
        n_cmp++; if (round_num !== 3'd2) begin n_bad++;
            $display("FAIL round_num_2: got %0d want 2", round_num); end
        run_countdown();
        game_over = 1'b1; p1_wins = 1'b1;
        tick(1);
        n_cmp++; if (state !== 3'd3 || p1_rounds !== 3'd2) begin n_bad++;
            $display("FAIL ko2: state=%0d p1r=%0d want 3/2", state, p1_rounds); end
        game_over = 1'b0; p1_wins = 1'b0;
        run_round_end(3'd4);
        n_cmp++; if (match_over !== 1'b1 || match_winner !== 2'b01 || round_num !== 3'd2 || p2_rounds !== 3'd0) begin n_bad++;
            $display("FAIL match_p1: mo=%0b mw=%0d rn=%0d p2r=%0d want 1/1/2/0",
                     match_over, match_winner, round_num, p2_rounds); end
    endtask

    task automatic test_restart;
        start_btn = 1'b1;
        tick(1);
        n_cmp++; if (state !== 3'd0 || match_over !== 1'b0 || round_num !== 3'd0 ||
                     match_winner !== 2'b00 || p1_rounds !== 3'd2) begin n_bad++;
            $display("FAIL to_idle: state=%0d mo=%0b rn=%0d mw=%0d p1r=%0d want 0/0/0/0/2",
                     state, match_over, round_num, match_winner, p1_rounds); end
        tick(1);
        n_cmp++; if (state !== 3'd0) begin n_bad++;
            $display("FAIL held_start: state=%0d want 0", state); end
        start_btn = 1'b0;
        tick(1);
        start_btn = 1'b1;
        tick(1);
        n_cmp++; if (state !== 3'd1 || round_reset !== 1'b1 || p1_rounds !== 3'd0 || round_num !== 3'd1) begin n_bad++;
            $display("FAIL restart: state=%0d rr=%0b p1r=%0d rn=%0d want 1/1/0/1",
                     state, round_reset, p1_rounds, round_num); end
        start_btn = 1'b0;
        run_countdown();
    endtask

    task automatic test_timeout;
        p1_health = 3'd3; p2_health = 3'd2;
        tick(3);
        n_cmp++; if (round_seconds !== 7'd45) begin n_bad++;
            $display("FAIL sec_before_wrap: got %0d want 45", round_seconds); end
        tick(1);
        n_cmp++; if (round_seconds !== 7'd44) begin n_bad++;
            $display("FAIL sec_first_wrap: got %0d want 44", round_seconds); end
        tick(176);
        n_cmp++; if (round_seconds !== 7'd0 || state !== 3'd2) begin n_bad++;
            $display("FAIL sec_zero: sec=%0d state=%0d want 0/2", round_seconds, state); end
        tick(1);
        n_cmp++; if (state !== 3'd3 || p1_rounds !== 3'd1 || p2_rounds !== 3'd0) begin n_bad++;
            $display("FAIL timeout_p1: state=%0d p1r=%0d p2r=%0d want 3/1/0", state, p1_rounds, p2_rounds); end
        run_round_end(3'd1);
        run_countdown();
        p1_health = 3'd2; p2_health = 3'd2;
        tick(181);
        n_cmp++; if (state !== 3'd3 || p1_rounds !== 3'd1 || p2_rounds !== 3'd0) begin n_bad++;
            $display("FAIL timeout_draw: state=%0d p1r=%0d p2r=%0d want 3/1/0", state, p1_rounds, p2_rounds); end
        run_round_end(3'd1);
        n_cmp++; if (round_num !== 3'd3) begin n_bad++;
            $display("FAIL round_num_3: got %0d want 3", round_num); end
        run_countdown();
    endtask

    task automatic test_pause;
        tick(20);
        n_cmp++; if (round_seconds !== 7'd40) begin n_bad++;
            $display("FAIL sec_40: got %0d want 40", round_seconds); end
        pause_btn = 1'b1;
        tick(1);
        n_cmp++; if (paused !== 1'b1 || game_active !== 1'b0) begin n_bad++;
            $display("FAIL pause_on: paused=%0b ga=%0b want 1/0", paused, game_active); end
        tick(100);
        n_cmp++; if (round_seconds !== 7'd40 || paused !== 1'b1 || game_active !== 1'b0 || state !== 3'd2) begin n_bad++;
            $display("FAIL pause_frozen: sec=%0d paused=%0b ga=%0b state=%0d want 40/1/0/2",
                     round_seconds, paused, game_active, state); end
        pause_btn = 1'b0;
        tick(1);
        pause_btn = 1'b1;
        tick(1);
        n_cmp++; if (paused !== 1'b0 || game_active !== 1'b1 || round_seconds !== 7'd40) begin n_bad++;
            $display("FAIL pause_off: paused=%0b ga=%0b sec=%0d want 0/1/40", paused, game_active, round_seconds); end
        pause_btn = 1'b0;
        tick(2);
        n_cmp++; if (round_seconds !== 7'd40) begin n_bad++;
            $display("FAIL resume_hold: got %0d want 40", round_seconds); end
        tick(1);
        n_cmp++; if (round_seconds !== 7'd39) begin n_bad++;
            $display("FAIL resume_wrap: got %0d want 39", round_seconds); end
        game_over = 1'b1; p2_wins = 1'b1;
        tick(1);
        n_cmp++; if (state !== 3'd3 || p2_rounds !== 3'd1 || p1_rounds !== 3'd1) begin n_bad++;
            $display("FAIL ko_p2: state=%0d p1r=%0d p2r=%0d want 3/1/1", state, p1_rounds, p2_rounds); end
        game_over = 1'b0; p2_wins = 1'b0;
        run_round_end(3'd1);
        run_countdown();
    endtask

    task automatic test_ko_vs_timeout;
        p1_health = 3'd3; p2_health = 3'd1;
        tick(180);
        n_cmp++; if (round_seconds !== 7'd0 || state !== 3'd2) begin n_bad++;
            $display("FAIL pre_tie: sec=%0d state=%0d want 0/2", round_seconds, state); end
        game_over = 1'b1; p2_wins = 1'b1;
        tick(1);
        n_cmp++; if (state !== 3'd3 || p2_rounds !== 3'd2 || p1_rounds !== 3'd1) begin n_bad++;
            $display("FAIL ko_priority: state=%0d p1r=%0d p2r=%0d want 3/1/2", state, p1_rounds, p2_rounds); end
        game_over = 1'b0; p2_wins = 1'b0;
        run_round_end(3'd4);
        n_cmp++; if (match_over !== 1'b1 || match_winner !== 2'b10 || round_num !== 3'd4) begin n_bad++;
            $display("FAIL match_p2: mo=%0b mw=%0d rn=%0d want 1/2/4", match_over, match_winner, round_num); end
    endtask

    task automatic test_draws;
        start_btn = 1'b1; tick(1);
        start_btn = 1'b0; tick(1);
        start_btn = 1'b1; tick(1);
        start_btn = 1'b0;
        n_cmp++; if (state !== 3'd1 || p1_rounds !== 3'd0 || p2_rounds !== 3'd0) begin n_bad++;
            $display("FAIL draw_start: state=%0d p1r=%0d p2r=%0d want 1/0/0", state, p1_rounds, p2_rounds); end
        for (int r = 1; r <= 5; r++) begin
            run_countdown();
            game_over = 1'b1; draw_game = 1'b1;
            tick(1);
            n_cmp++; if (state !== 3'd3 || p1_rounds !== 3'd0 || p2_rounds !== 3'd0 || round_num !== 3'(r)) begin n_bad++;
                $display("FAIL draw_round%0d: state=%0d p1r=%0d p2r=%0d rn=%0d want 3/0/0/%0d",
                         r, state, p1_rounds, p2_rounds, round_num, r); end
            game_over = 1'b0; draw_game = 1'b0;
            run_round_end((r < 5) ? 3'd1 : 3'd4);
        end
        n_cmp++; if (match_over !== 1'b1 || match_winner !== 2'b00 || round_num !== 3'd5) begin n_bad++;
            $display("FAIL match_draw: mo=%0b mw=%0d rn=%0d want 1/0/5", match_over, match_winner, round_num); end
    endtask

    task automatic test_async_reset;
        start_btn = 1'b1; tick(1);
        start_btn = 1'b0; tick(1);
        start_btn = 1'b1; tick(1);
        start_btn = 1'b0;
        run_countdown();
        tick(5);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({game_active, round_reset, state, paused, round_num, round_seconds,
                      p1_rounds, p2_rounds, match_over, match_winner} !== '0) begin n_bad++;
            $display("FAIL async_reset: state=%0d ga=%0b rn=%0d sec=%0d want all 0",
                     state, game_active, round_num, round_seconds); end
        tick(2);
        reset_n = 1'b1;
        tick(2);
        n_cmp++; if (state !== 3'd0 || round_num !== 3'd0) begin n_bad++;
            $display("FAIL post_reset_idle: state=%0d rn=%0d want 0/0", state, round_num); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_ko_match();
        test_restart();
        test_timeout();
        test_pause();
        test_ko_vs_timeout();
        test_draws();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
